// File: rtl/operand_fifo_pkg.sv
// Shared constants and helpers for the operand FIFO that feeds the 32-bit enable register.
package operand_fifo_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 4;

    // Pointer width: index bits plus one wrap bit, which separates full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/operand_fifo_mem.sv
// DEPTH x WIDTH storage for operand_fifo: synchronous write port, asynchronous read port.
module operand_fifo_mem
    import operand_fifo_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push.
    // NOTE: no reset on the array; resetting it would prevent RAM/regfile inference and
    // is unnecessary because the pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/operand_fifo.sv
// First-word fall-through FIFO ahead of the enable register: pop_valid is the register's
// load enable, pop_data its data input. Optional sticky overflow flag under the macro
// OPERAND_FIFO_OVERFLOW_ERR_EN (adds output err_overflow).
module operand_fifo
    import operand_fifo_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [WIDTH-1:0]  push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [WIDTH-1:0]  pop_data,
`ifdef OPERAND_FIFO_OVERFLOW_ERR_EN
    output logic              err_overflow,
`endif
    output logic [ADDR_W:0]   count
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             full;
    logic             push_fire;
    logic             pop_fire;
    logic [WIDTH-1:0] rdata;

    // Equal pointers mean empty; equal index with opposite wrap bits means full.
    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[ADDR_W-1:0] == wr_ptr[ADDR_W-1:0]) &&
                   (rd_ptr[ADDR_W] != wr_ptr[ADDR_W]);

    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign push_fire  = push_valid && !full;
    assign pop_fire   = pop_ready && !empty;

    // Head word is forced to zero when empty so the register input is deterministic.
    assign pop_data = empty ? '0 : rdata;

    operand_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock (clock),
        .we    (push_fire),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (push_data),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (rdata)
    );

    // Advance pointers on accepted transfers and track occupancy alongside them.
    // NOTE: state registers use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + PTR_ONE;
                2'b01:   count <= count - PTR_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef OPERAND_FIFO_OVERFLOW_ERR_EN
    // Sticky flag: producer drove push_valid while the FIFO was full.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_overflow <= 1'b0;
        end else if (push_valid && full) begin
            err_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_fifo.sv
// Scoreboard bench for operand_fifo: stimulus queues expected words, a negedge monitor
// compares every popped word in order; direct checks cover flags and occupancy.
module tb_operand_fifo;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [31:0] push_data = '0;
    logic        pop_valid;
    logic        pop_ready = 1'b0;
    logic [31:0] pop_data;
    logic [2:0]  count;
`ifdef OPERAND_FIFO_OVERFLOW_ERR_EN
    logic        err_overflow;
`endif

    logic [31:0] sb [$];
    logic [31:0] reg_q;
    int          checks = 0;
    int          errors = 0;

    operand_fifo dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
`ifdef OPERAND_FIFO_OVERFLOW_ERR_EN
        .err_overflow (err_overflow),
`endif
        .count      (count)
    );

    always #5 clock = ~clock;

    // Downstream enable register model fed by the FIFO head.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) reg_q <= '0;
        else if (pop_valid && pop_ready) reg_q <= pop_data;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] d, input bit accept);
        push_valid = 1'b1;
        push_data  = d;
        if (accept) sb.push_back(d);
    endtask

    // Monitor: every pop that will fire at the next edge must match the scoreboard head.
    always @(negedge clock) begin
        if (reset_n && pop_valid && pop_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", pop_data, 32'hFFFF_FFFF);
            end else begin
                check("pop_data_order", pop_data, sb.pop_front());
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Reset, then idle.
        repeat (3) @(posedge clock);
        #1;
        check("rst_pop_valid", pop_valid, 0);
        check("rst_push_ready", push_ready, 1);
        check("rst_count", count, 0);
        check("rst_pop_data", pop_data, 0);
`ifdef OPERAND_FIFO_OVERFLOW_ERR_EN
        check("rst_err_overflow", err_overflow, 0);
`endif
        reset_n = 1'b1;
        step();
        step();
        check("idle_pop_valid", pop_valid, 0);
        check("idle_push_ready", push_ready, 1);
        check("idle_count", count, 0);
        check("idle_pop_data", pop_data, 0);

        // 2. Single word into the register.
        pop_ready = 1'b1;
        drive_push(32'd31, 1'b1);
        step();
        push_valid = 1'b0;
        check("single_pop_valid", pop_valid, 1);
        check("single_pop_data", pop_data, 31);
        check("single_count", count, 1);
        step();
        check("single_count_after", count, 0);
        check("single_pop_valid_after", pop_valid, 0);
        check("single_reg_q", reg_q, 31);
        check("single_pop_data_empty", pop_data, 0);

        // 3. Fill to full, push while full (with and without a concurrent pop), drain.
        pop_ready = 1'b0;
        drive_push(32'd31, 1'b1);   step();
        drive_push(32'd127, 1'b1);  step();
        drive_push(32'd1023, 1'b1); step();
        drive_push(32'd7, 1'b1);    step();
        check("full_count", count, 4);
        check("full_push_ready", push_ready, 0);
        drive_push(32'd99, 1'b0);   step();
        check("full_ignore_count", count, 4);
        pop_ready = 1'b1;
        drive_push(32'd99, 1'b0);   step();
        check("full_push_pop_count", count, 3);
        push_valid = 1'b0;
        repeat (3) step();
        check("drain_count", count, 0);
        check("drain_pop_valid", pop_valid, 0);

        // 4. Steady push+pop at count=2, crossing the pointer wrap several times.
        pop_ready = 1'b0;
        drive_push(32'd101, 1'b1); step();
        drive_push(32'd102, 1'b1); step();
        check("stream_prefill_count", count, 2);
        pop_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive_push(i, 1'b1);
            step();
            check("stream_count", count, 2);
        end
        push_valid = 1'b0;
        repeat (2) step();
        check("stream_drain_count", count, 0);

        // 5. Asynchronous reset with three words queued.
        pop_ready = 1'b0;
        drive_push(32'd5, 1'b1); step();
        drive_push(32'd6, 1'b1); step();
        drive_push(32'd7, 1'b1); step();
        push_valid = 1'b0;
        check("midrst_pre_count", count, 3);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_pop_valid", pop_valid, 0);
        check("midrst_count", count, 0);
        check("midrst_pop_data", pop_data, 0);
        #1;
        reset_n = 1'b1;
        step();
        drive_push(32'd1023, 1'b1);
        step();
        push_valid = 1'b0;
        check("postrst_pop_valid", pop_valid, 1);
        check("postrst_pop_data", pop_data, 1023);
        pop_ready = 1'b1;
        step();
        check("postrst_count", count, 0);
        pop_ready = 1'b0;

`ifdef OPERAND_FIFO_OVERFLOW_ERR_EN
        // 6. Overflow flag is sticky until reset.
        check("ovf_initial", err_overflow, 0);
        drive_push(32'd11, 1'b1); step();
        drive_push(32'd12, 1'b1); step();
        drive_push(32'd13, 1'b1); step();
        drive_push(32'd14, 1'b1); step();
        check("ovf_not_yet", err_overflow, 0);
        drive_push(32'd15, 1'b0); step();
        push_valid = 1'b0;
        check("ovf_set", err_overflow, 1);
        pop_ready = 1'b1;
        repeat (4) step();
        pop_ready = 1'b0;
        check("ovf_drained_count", count, 0);
        check("ovf_sticky", err_overflow, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ovf_cleared", err_overflow, 0);
        reset_n = 1'b1;
        step();
`endif

        @(negedge clock);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
